// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline hazard/sequencing controller
// and the stage registers it drives.
package pipeline_pkg;

    localparam int REG_W  = 5;
    localparam int CTRL_W = 32;

    // Stage registers load this on flush: every control bit cleared makes a bubble.
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: an ID source register matches the rd of a load in EX.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Per-stage enable/flush generation, data-memory wait handling with a
// watchdog that halts the core, and a saturating stall counter.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_W-1:0]     id_rs1,
    input  logic [REG_W-1:0]     id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_W-1:0]     ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 dmem_ready,
    output logic                 dmem_valid,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_en,
    output logic                 exmem_en,
    output logic                 memwb_en,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic                 memwb_flush,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        load_use;
    logic        mem_stall;
    logic        dvalid;
    stage_ctrl_t ctl;

    hazard_detect u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    assign mem_stall = mem_req && !dmem_ready;

    always_comb begin
        ctl    = CTRL_IDLE;
        dvalid = 1'b0;
        if (rst_n && (state == RUN || state == MEM_WAIT)) begin
            dvalid = mem_req;
            if (mem_stall) begin
                // Freeze everything up to EX/MEM; WB gets a bubble meanwhile.
                ctl.memwb_flush = 1'b1;
            end else begin
                ctl.pc_en    = 1'b1;
                ctl.ifid_en  = 1'b1;
                ctl.idex_en  = 1'b1;
                ctl.exmem_en = 1'b1;
                ctl.memwb_en = 1'b1;
                // A taken branch squashes the ID instruction, so its hazard is moot.
                if (ex_branch_taken) begin
                    ctl.ifid_flush = 1'b1;
                    ctl.idex_flush = 1'b1;
                end else if (load_use) begin
                    ctl.pc_en      = 1'b0;
                    ctl.ifid_en    = 1'b0;
                    ctl.idex_flush = 1'b1;
                end
            end
        end
    end

    assign pc_en       = ctl.pc_en;
    assign ifid_en     = ctl.ifid_en;
    assign idex_en     = ctl.idex_en;
    assign exmem_en    = ctl.exmem_en;
    assign memwb_en    = ctl.memwb_en;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_flush  = ctl.idex_flush;
    assign memwb_flush = ctl.memwb_flush;
    assign dmem_valid  = dvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TIMEOUT_C) begin
                        state   <= HALT;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HALT: ;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (!ctl.pc_en && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_TIMEOUT=4 and CNT_WIDTH=4.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic       mem_req, dmem_ready;
    logic       dmem_valid, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, memwb_flush, mem_err;
    logic [3:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, memwb_fl, dmem_valid}
    logic [8:0] ctl;
    assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, memwb_flush, dmem_valid};

    localparam logic [8:0] C_ZERO   = 9'b00000_000_0;
    localparam logic [8:0] C_RUN    = 9'b11111_000_0;
    localparam logic [8:0] C_RUNMEM = 9'b11111_000_1;
    localparam logic [8:0] C_LU     = 9'b00111_010_0;
    localparam logic [8:0] C_BR     = 9'b11111_110_0;
    localparam logic [8:0] C_BRMEM  = 9'b11111_110_1;
    localparam logic [8:0] C_FRZ    = 9'b00000_001_1;

    pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .dmem_ready(dmem_ready), .dmem_valid(dmem_valid),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_flush(memwb_flush), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
        mem_req = 0; dmem_ready = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("reset_ctl", 32'(ctl), 32'(C_ZERO));
        chk("reset_err", 32'(mem_err), 0);
        chk("reset_cnt", 32'(stall_cnt), 0);
        chk("reset_state", 32'(dut.state), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("run_idle", 32'(ctl), 32'(C_RUN));
        tick();
        chk("run_idle_cnt", 32'(stall_cnt), 0);

        // Load-use via rs2
        ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
        #1;
        chk("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
        tick();
        chk("lu_rs2_cnt", 32'(stall_cnt), 1);

        // rd == x0 is never a hazard
        ex_rd = 0; id_rs2 = 0;
        #1;
        chk("lu_x0_ctl", 32'(ctl), 32'(C_RUN));
        // Matching register but not read
        ex_rd = 9; id_rs2 = 9; id_use_rs2 = 0;
        #1;
        chk("lu_nouse_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        chk("lu_x0_cnt", 32'(stall_cnt), 1);

        // Load-use via rs1
        id_rs1 = 7; id_use_rs1 = 1; ex_rd = 7;
        #1;
        chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
        tick();
        chk("lu_rs1_cnt", 32'(stall_cnt), 2);

        // Branch wins over load-use
        ex_branch_taken = 1;
        #1;
        chk("br_lu_ctl", 32'(ctl), 32'(C_BR));
        tick();
        chk("br_lu_cnt", 32'(stall_cnt), 2);

        // Zero-wait memory access in RUN
        idle_inputs();
        mem_req = 1; dmem_ready = 1;
        #1;
        chk("zw_ctl", 32'(ctl), 32'(C_RUNMEM));
        tick();
        chk("zw_state", 32'(dut.state), 0);

        // Three wait cycles then release
        dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_ctl", 32'(ctl), 32'(C_FRZ));
            tick();
            chk("mw_state", 32'(dut.state), 1);
            chk("mw_cnt", 32'(stall_cnt), 32'(3 + i));
        end
        dmem_ready = 1;
        #1;
        chk("mw_rel_ctl", 32'(ctl), 32'(C_RUNMEM));
        tick();
        chk("mw_rel_state", 32'(dut.state), 0);
        chk("mw_rel_cnt", 32'(stall_cnt), 5);

        // Taken branch held in EX across a two-cycle wait
        ex_branch_taken = 1; dmem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("brw_ctl", 32'(ctl), 32'(C_FRZ));
            tick();
        end
        chk("brw_cnt", 32'(stall_cnt), 7);
        dmem_ready = 1;
        #1;
        chk("brw_rel_ctl", 32'(ctl), 32'(C_BRMEM));
        tick();
        chk("brw_rel_state", 32'(dut.state), 0);
        chk("brw_rel_cnt", 32'(stall_cnt), 7);

        // Watchdog: one RUN stall cycle plus four MEM_WAIT cycles, then HALT
        ex_branch_taken = 0; dmem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("wd_ctl", 32'(ctl), 32'(C_FRZ));
            tick();
            chk("wd_state", 32'(dut.state), (i == 4) ? 2 : 1);
            chk("wd_err", 32'(mem_err), (i == 4) ? 1 : 0);
        end
        chk("wd_cnt", 32'(stall_cnt), 12);
        #1;
        chk("halt_ctl", 32'(ctl), 32'(C_ZERO));
        dmem_ready = 1;
        #1;
        chk("halt_ready_ctl", 32'(ctl), 32'(C_ZERO));
        tick();
        chk("halt_ready_state", 32'(dut.state), 2);
        chk("halt_ready_err", 32'(mem_err), 1);
        chk("halt_cnt", 32'(stall_cnt), 13);

        // Reset pulse clears everything asynchronously
        rst_n = 0;
        #1;
        chk("rst_state", 32'(dut.state), 0);
        chk("rst_err", 32'(mem_err), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_ctl", 32'(ctl), 32'(C_ZERO));
        tick();
        rst_n = 1;

        // Reset in the middle of MEM_WAIT drops the request
        dmem_ready = 0;
        tick();
        tick();
        chk("mwr_state", 32'(dut.state), 1);
        rst_n = 0;
        #1;
        chk("mwr_rst_state", 32'(dut.state), 0);
        chk("mwr_rst_dv", 32'(dmem_valid), 0);
        tick();
        rst_n = 1;

        // Saturation: 20 stalled cycles on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("sat_cnt", 32'(stall_cnt), (i + 1 > 15) ? 15 : (i + 1));
        end
        chk("sat_final", 32'(stall_cnt), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
